fir_stream_p: RTL and testbench
===============================

Name: fir_stream_p

Overview:
- Parametrised streaming FIR engine; successor to the fixed 32-tap FIR stage of the FAS block.
- Adds generic tap count, operand widths and fixed-point formats, a run-time coefficient RAM load port, and round-half-up with saturation.
- Adds a synchronous flush, an overflow flag, and stall-tolerant input (gaps in data_valid).
- Sits between the sample input and the FFT/analysis stages; accepts at most one sample per cycle.

Parameters:
- TAPS, 32, number of taps (2..64).
- DATA_W, 16, input sample width, signed.
- DATA_FRAC, 8, input fraction bits.
- COEF_W, 20, coefficient width, signed.
- COEF_FRAC, 16, coefficient fraction bits.
- OUT_W, 16, output width, signed.
- OUT_FRAC, 8, output fraction bits.
- Constraint: DATA_FRAC+COEF_FRAC-OUT_FRAC >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush of delay line and pipeline.
- data_valid  in  1  sample strobe.
- data  in  DATA_W  signed sample.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  clog2(TAPS)  tap index.
- coef_data  in  COEF_W  signed coefficient.
- fir_valid  out  1  output strobe, one cycle per result.
- fir_d  out  OUT_W  signed filtered sample.
- ovf  out  1  saturation occurred on this fir_valid.

Behaviour:
- Reset (rst=0, async): delay line, coefficients, fill counter and pipeline all 0. fir_valid=0, fir_d=0, ovf=0.
- Accept: a sample is accepted on a rising edge with data_valid=1 and clr=0. It shifts into x[0]; x[k] moves to x[k+1]; x[TAPS-1] is dropped.
- Fill counter: counts accepted samples and saturates at TAPS.
  - Result for an accepted sample is emitted only if the counter is TAPS-1 or TAPS at acceptance.
  - So the first fir_valid corresponds to the TAPS-th accepted sample.
- Pipeline, 2 stages, latency 2 cycles from accept edge to fir_valid high:
  - Stage 1 registers all products p[k]=x[k]*h[k], each DATA_W+COEF_W bits.
  - Stage 2 registers sum, round and saturate into fir_d, ovf and fir_valid.
- Stalls: no accepted sample means no fir_valid. fir_d holds its last value while fir_valid=0. Gaps never change results.
- Arithmetic:
  - Accumulator width DATA_W+COEF_W+clog2(TAPS), full precision, no intermediate truncation.
  - S = DATA_FRAC+COEF_FRAC-OUT_FRAC.
  - Rounding: add 2^(S-1), then arithmetic shift right by S (round half toward +inf).
  - Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; ovf=1 when clamped, otherwise 0.
- y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k].
- Coefficient writes:
  - Accepted any cycle, including mid-stream.
  - A sample accepted in the same cycle as a write uses the old h[addr]; the new value applies from the next accepted sample.
  - coef_addr >= TAPS: write ignored.
  - Coefficients are not cleared by clr.
- clr:
  - Zeroes the delay line and fill counter.
  - Squashes both pipeline stages, so no fir_valid for in-flight samples.
  - fir_valid=0 next cycle.
  - clr together with data_valid: clr wins and the sample is dropped.
  - After clr, TAPS new samples are needed before the next fir_valid.
- Mid-operation reset: immediate clear of all state including coefficients. Outputs low until refill.
- No backpressure: the consumer must take every fir_valid pulse.

Test Plan:
1. Moving average (defaults): load h[k]=0x01000 (1/16) for k=0..31; stream 40 samples of 0x0100 (1.0) continuously -> first fir_valid exactly 2 cycles after 32nd accept; fir_d=0x0200; then 8 more outputs of 0x0200; ovf=0.
2. Impulse: h[k]=k*256 (k/256); 31 zeros, then 0x0100, then 40 zeros -> first 32 outputs 0x0000,0x0001,...,0x001F, then 0x0000.
3. Saturation: all h=0x7FFFF; 32 samples 0x7FFF -> fir_d=0x7FFF, ovf=1; then 32 samples 0x8000 -> reaches 0x8000, ovf=1.
4. Rounding: h[0]=0x08000 (0.5), others 0; after fill, input 0x0001 -> 0x0001; input 0xFFFF -> 0x0000; input 0xFFFD -> 0xFFFF.
5. Stall/coef update: repeat scenario 1 with random 0-3 cycle gaps between samples -> identical fir_d sequence, each fir_valid 2 cycles after its accept. Then write h[0]=0 in the same cycle as a sample accept -> that output is still 0x0200; the next one is 0x01F0.
6. clr/reset: clr after 40 samples, asserted together with data_valid -> in-flight outputs squashed, sample dropped; fir_valid stays 0 until 32 further accepts; h retained. rst low mid-stream -> outputs 0 immediately and h reads back as zero (all-zero outputs after refill).

Source files
------------

// File: rtl/fir_stream_p.sv
// fir_stream_p -- parametrised streaming FIR engine.
//
// Direct-form FIR with a run-time loadable coefficient bank, full-precision
// accumulation, round-half-up and output saturation. Accepts at most one
// sample per cycle; gaps in data_valid never change results.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears everything incl. coefs)
//   clr        synchronous flush of delay line, fill counter and pipeline
//   data_valid sample strobe
//   data       signed input sample (DATA_W, DATA_FRAC fraction bits)
//   coef_we    coefficient write enable
//   coef_addr  tap index; writes to indices >= TAPS are ignored
//   coef_data  signed coefficient (COEF_W, COEF_FRAC fraction bits)
//   fir_valid  one-cycle strobe per result
//   fir_d      signed result (OUT_W, OUT_FRAC fraction bits), holds between strobes
//   ovf        result was clamped by saturation
//
// Timing: accept edge E0 shifts the delay line, E1 registers the products,
// E2 registers the rounded/saturated sum with fir_valid.
module fir_stream_p #(
  parameter int TAPS      = 32,
  parameter int DATA_W    = 16,
  parameter int DATA_FRAC = 8,
  parameter int COEF_W    = 20,
  parameter int COEF_FRAC = 16,
  parameter int OUT_W     = 16,
  parameter int OUT_FRAC  = 8,
  localparam int ADDR_W   = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     data_valid,
  input  logic signed [DATA_W-1:0] data,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     fir_valid,
  output logic signed [OUT_W-1:0]  fir_d,
  output logic                     ovf
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam int SHIFT  = DATA_FRAC + COEF_FRAC - OUT_FRAC;
  localparam int FILL_W = $clog2(TAPS + 1);

  localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0] OMAX = {1'b0, {(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [COEF_W-1:0] h    [TAPS];
  logic signed [PROD_W-1:0] prod [TAPS];
  logic [FILL_W-1:0]        fill;
  logic                     acc_v;
  logic                     prod_v;

  // Coefficient writes land one cycle late so that the sample accepted in
  // the same cycle still multiplies against the old value at E1.
  logic                     pend_we;
  logic [ADDR_W-1:0]        pend_addr;
  logic signed [COEF_W-1:0] pend_data;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    shifted;
  logic signed [OUT_W-1:0]  sat_y;
  logic                     sat_o;

  // Delay line and fill counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      fill  <= '0;
      acc_v <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      fill  <= '0;
      acc_v <= 1'b0;
    end else if (data_valid) begin
      x[0] <= data;
      for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
      if (fill != FILL_W'(TAPS)) fill <= fill + FILL_W'(1);
      // Only samples that complete a full window produce a result.
      acc_v <= (fill >= FILL_W'(TAPS - 1));
    end else begin
      acc_v <= 1'b0;
    end
  end

  // Coefficient bank (survives clr, cleared only by rst)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) h[k] <= '0;
      pend_we   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      pend_we   <= coef_we && ({1'b0, coef_addr} < (ADDR_W+1)'(TAPS));
      pend_addr <= coef_addr;
      pend_data <= coef_data;
      for (int k = 0; k < TAPS; k++) begin
        if (pend_we && (pend_addr == ADDR_W'(k))) h[k] <= pend_data;
      end
    end
  end

  // Stage 1: products
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
      prod_v <= 1'b0;
    end else begin
      prod_v <= acc_v && !clr;
      if (acc_v && !clr) begin
        for (int k = 0; k < TAPS; k++) prod[k] <= PROD_W'(x[k]) * PROD_W'(h[k]);
      end
    end
  end

  // Full-precision sum, round half toward +inf, saturate
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod[k]);
    rnd_sum = (ACC_W+1)'(acc) + HALF;
    shifted = rnd_sum >>> SHIFT;
    sat_o   = 1'b0;
    sat_y   = shifted[OUT_W-1:0];
    if (shifted > OMAX) begin
      sat_y = OMAX[OUT_W-1:0];
      sat_o = 1'b1;
    end else if (shifted < OMIN) begin
      sat_y = OMIN[OUT_W-1:0];
      sat_o = 1'b1;
    end
  end

  // Stage 2: output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fir_valid <= 1'b0;
      fir_d     <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      fir_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      fir_valid <= prod_v;
      if (prod_v) begin
        fir_d <= sat_y;
        ovf   <= sat_o;
      end else begin
        ovf   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_p.sv
// tb_fir_stream_p -- directed self-checking bench for fir_stream_p
// (default parameters: 32 taps, Q8 data, Q16 coefficients, Q8 output).
module tb_fir_stream_p;

  logic               clk = 1'b0;
  logic               rst;
  logic               clr;
  logic               data_valid;
  logic signed [15:0] data;
  logic               coef_we;
  logic [4:0]         coef_addr;
  logic signed [19:0] coef_data;
  logic               fir_valid;
  logic signed [15:0] fir_d;
  logic               ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] oq_d[$];
  logic        oq_o[$];
  int          oq_c[$];

  fir_stream_p dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .data_valid (data_valid),
    .data       (data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .fir_valid  (fir_valid),
    .fir_d      (fir_d),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // Output monitor: captures every strobe with its edge number
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (fir_valid) begin
        oq_d.push_back(fir_d);
        oq_o.push_back(ovf);
        oq_c.push_back(cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    oq_d.delete();
    oq_o.delete();
    oq_c.delete();
  endtask

  task automatic drive(input logic dv, input logic [15:0] d, input logic we,
                       input logic [4:0] a, input logic [19:0] cd, input logic c,
                       output int acc_c);
    @(negedge clk);
    data_valid = dv;
    data       = d;
    coef_we    = we;
    coef_addr  = a;
    coef_data  = cd;
    clr        = c;
    @(posedge clk);
    #1;
    acc_c = cyc;
  endtask

  task automatic send(input logic [15:0] d, output int ac);
    drive(1'b1, d, 1'b0, 5'd0, 20'd0, 1'b0, ac);
  endtask

  task automatic idle(input int n);
    int dm;
    for (int i = 0; i < n; i++) drive(1'b0, 16'd0, 1'b0, 5'd0, 20'd0, 1'b0, dm);
  endtask

  task automatic wr(input int k, input logic [19:0] v);
    int dm;
    drive(1'b0, 16'd0, 1'b1, 5'(k), v, 1'b0, dm);
  endtask

  task automatic flush();
    int dm;
    drive(1'b0, 16'd0, 1'b0, 5'd0, 20'd0, 1'b1, dm);
    idle(2);
    clear_q();
  endtask

  task automatic test_reset();
    n_tests++;
    if (fir_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b exp 0", fir_valid);
    end
    n_tests++;
    if (fir_d !== 16'h0000) begin
      n_fail++; $display("FAIL reset_d got %h exp 0000", fir_d);
    end
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf);
    end
  endtask

  task automatic test_moving_avg();
    int ac[40];
    for (int k = 0; k < 32; k++) wr(k, 20'h01000);
    flush();
    for (int i = 0; i < 40; i++) send(16'h0100, ac[i]);
    idle(4);
    n_tests++;
    if (oq_d.size() != 9) begin
      n_fail++; $display("FAIL ma_count got %0d exp 9", oq_d.size());
    end
    for (int i = 0; i < 9 && i < oq_d.size(); i++) begin
      n_tests++;
      if (oq_d[i] !== 16'h0200 || oq_o[i] !== 1'b0) begin
        n_fail++; $display("FAIL ma_out[%0d] got %h/%b exp 0200/0", i, oq_d[i], oq_o[i]);
      end
      n_tests++;
      if (oq_c[i] != ac[31+i] + 2) begin
        n_fail++; $display("FAIL ma_latency[%0d] got edge %0d exp %0d", i, oq_c[i], ac[31+i] + 2);
      end
    end
  endtask

  task automatic test_impulse();
    int dm;
    for (int k = 0; k < 32; k++) wr(k, 20'(k * 256));
    flush();
    for (int i = 0; i < 31; i++) send(16'h0000, dm);
    send(16'h0100, dm);
    for (int i = 0; i < 40; i++) send(16'h0000, dm);
    idle(4);
    n_tests++;
    if (oq_d.size() != 41) begin
      n_fail++; $display("FAIL imp_count got %0d exp 41", oq_d.size());
    end
    for (int i = 0; i < 41 && i < oq_d.size(); i++) begin
      logic [15:0] e;
      e = (i < 32) ? 16'(i) : 16'h0000;
      n_tests++;
      if (oq_d[i] !== e || oq_o[i] !== 1'b0) begin
        n_fail++; $display("FAIL imp_out[%0d] got %h/%b exp %h/0", i, oq_d[i], oq_o[i], e);
      end
    end
  endtask

  task automatic test_saturation();
    int dm;
    for (int k = 0; k < 32; k++) wr(k, 20'h7FFFF);
    flush();
    for (int i = 0; i < 32; i++) send(16'h7FFF, dm);
    for (int i = 0; i < 32; i++) send(16'h8000, dm);
    idle(4);
    n_tests++;
    if (oq_d.size() != 33) begin
      n_fail++; $display("FAIL sat_count got %0d exp 33", oq_d.size());
    end
    if (oq_d.size() == 33) begin
      n_tests++;
      if (oq_d[0] !== 16'h7FFF || oq_o[0] !== 1'b1) begin
        n_fail++; $display("FAIL sat_pos got %h/%b exp 7fff/1", oq_d[0], oq_o[0]);
      end
      // half positive, half negative: -8388592 rounds to -128
      n_tests++;
      if (oq_d[16] !== 16'hFF80 || oq_o[16] !== 1'b0) begin
        n_fail++; $display("FAIL sat_mid got %h/%b exp ff80/0", oq_d[16], oq_o[16]);
      end
      n_tests++;
      if (oq_d[32] !== 16'h8000 || oq_o[32] !== 1'b1) begin
        n_fail++; $display("FAIL sat_neg got %h/%b exp 8000/1", oq_d[32], oq_o[32]);
      end
    end
  endtask

  task automatic test_rounding();
    int dm;
    logic [15:0] exp_d[4];
    exp_d[0] = 16'h0000; exp_d[1] = 16'h0001; exp_d[2] = 16'h0000; exp_d[3] = 16'hFFFF;
    wr(0, 20'h08000);
    for (int k = 1; k < 32; k++) wr(k, 20'h00000);
    flush();
    for (int i = 0; i < 32; i++) send(16'h0000, dm);
    send(16'h0001, dm);
    send(16'hFFFF, dm);
    send(16'hFFFD, dm);
    idle(4);
    n_tests++;
    if (oq_d.size() != 4) begin
      n_fail++; $display("FAIL rnd_count got %0d exp 4", oq_d.size());
    end
    for (int i = 0; i < 4 && i < oq_d.size(); i++) begin
      n_tests++;
      if (oq_d[i] !== exp_d[i] || oq_o[i] !== 1'b0) begin
        n_fail++; $display("FAIL rnd_out[%0d] got %h/%b exp %h/0", i, oq_d[i], oq_o[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_stall_coef();
    int ac[40];
    int a0, a1;
    for (int k = 0; k < 32; k++) wr(k, 20'h01000);
    flush();
    for (int i = 0; i < 40; i++) begin
      send(16'h0100, ac[i]);
      idle(int'($urandom_range(0, 3)));
    end
    idle(4);
    n_tests++;
    if (oq_d.size() != 9) begin
      n_fail++; $display("FAIL stall_count got %0d exp 9", oq_d.size());
    end
    for (int i = 0; i < 9 && i < oq_d.size(); i++) begin
      n_tests++;
      if (oq_d[i] !== 16'h0200 || oq_c[i] != ac[31+i] + 2) begin
        n_fail++;
        $display("FAIL stall_out[%0d] got %h@%0d exp 0200@%0d", i, oq_d[i], oq_c[i], ac[31+i] + 2);
      end
    end
    clear_q();
    drive(1'b1, 16'h0100, 1'b1, 5'd0, 20'h00000, 1'b0, a0);
    send(16'h0100, a1);
    idle(4);
    n_tests++;
    if (oq_d.size() != 2) begin
      n_fail++; $display("FAIL coefupd_count got %0d exp 2", oq_d.size());
    end else begin
      n_tests++;
      if (oq_d[0] !== 16'h0200) begin
        n_fail++; $display("FAIL coefupd_old got %h exp 0200", oq_d[0]);
      end
      n_tests++;
      if (oq_d[1] !== 16'h01F0) begin
        n_fail++; $display("FAIL coefupd_new got %h exp 01f0", oq_d[1]);
      end
    end
  endtask

  task automatic test_clr_reset();
    int dm;
    clear_q();
    for (int i = 0; i < 5; i++) send(16'h0100, dm);
    // clr with a sample: clr wins, the last two in-flight results vanish
    drive(1'b1, 16'h7FFF, 1'b0, 5'd0, 20'd0, 1'b1, dm);
    n_tests++;
    if (fir_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_squash_valid got %b exp 0", fir_valid);
    end
    idle(4);
    n_tests++;
    if (oq_d.size() != 3) begin
      n_fail++; $display("FAIL clr_inflight_count got %0d exp 3", oq_d.size());
    end
    for (int i = 0; i < 3 && i < oq_d.size(); i++) begin
      n_tests++;
      if (oq_d[i] !== 16'h01F0) begin
        n_fail++; $display("FAIL clr_pre[%0d] got %h exp 01f0", i, oq_d[i]);
      end
    end
    clear_q();
    for (int i = 0; i < 31; i++) send(16'h0100, dm);
    idle(3);
    n_tests++;
    if (oq_d.size() != 0) begin
      n_fail++; $display("FAIL clr_refill_early got %0d strobes exp 0", oq_d.size());
    end
    send(16'h0100, dm);
    idle(3);
    n_tests++;
    if (oq_d.size() != 1) begin
      n_fail++; $display("FAIL clr_refill_count got %0d exp 1", oq_d.size());
    end else begin
      n_tests++;
      if (oq_d[0] !== 16'h01F0) begin
        n_fail++; $display("FAIL clr_coef_kept got %h exp 01f0", oq_d[0]);
      end
    end
    clear_q();
    for (int i = 0; i < 3; i++) send(16'h0100, dm);
    n_tests++;
    if (fir_valid !== 1'b1 || fir_d !== 16'h01F0) begin
      n_fail++; $display("FAIL prerst_out got %b/%h exp 1/01f0", fir_valid, fir_d);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (fir_valid !== 1'b0 || fir_d !== 16'h0000 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got %b/%h/%b exp 0/0000/0", fir_valid, fir_d, ovf);
    end
    @(negedge clk);
    data_valid = 1'b0;
    coef_we    = 1'b0;
    clr        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_q();
    for (int i = 0; i < 32; i++) send(16'h0100, dm);
    idle(4);
    n_tests++;
    if (oq_d.size() != 1) begin
      n_fail++; $display("FAIL rst_refill_count got %0d exp 1", oq_d.size());
    end else begin
      n_tests++;
      if (oq_d[0] !== 16'h0000 || oq_o[0] !== 1'b0) begin
        n_fail++; $display("FAIL rst_coef_zero got %h/%b exp 0000/0", oq_d[0], oq_o[0]);
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    clr        = 1'b0;
    data_valid = 1'b0;
    data       = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_moving_avg();
    test_impulse();
    test_saturation();
    test_rounding();
    test_stall_coef();
    test_clr_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
